// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-access stage: FSM state
// encoding, default bus watchdog limit, and the MEM/WB register payload.
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Default number of WAIT cycles allowed before the access is abandoned.
    localparam int TIMEOUT_DEFAULT = 255;

    // One MEM/WB pipeline entry, including the exception flags that travel
    // alongside it so they pulse in the same cycle as the entry.
    typedef struct packed {
        logic [31:0] dout;
        logic [31:0] alu;
        logic [4:0]  rw;
        logic        regwr;
        logic        memtoreg;
        logic        exc_ade;
        logic        bus_err;
        logic        exc_ov;
    } wb_entry_t;

    localparam wb_entry_t WB_BUBBLE = '{
        dout:     32'd0,
        alu:      32'd0,
        rw:       5'd0,
        regwr:    1'b0,
        memtoreg: 1'b0,
        exc_ade:  1'b0,
        bus_err:  1'b0,
        exc_ov:   1'b0
    };

    // Word accesses must have the two low address bits clear.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/reg_mem_wb.sv
// MEM/WB pipeline register: asynchronous clear, bubble insertion and load
// enable. A bubble takes priority over a load so a stalled instruction is
// never written back twice.
module reg_mem_wb
    import mem_access_pkg::*;
(
    input  logic      clk,
    input  logic      clr,
    input  logic      load_en,
    input  logic      bubble,
    input  wb_entry_t d,
    output wb_entry_t q
);

    // Entry register: clear, bubble, load, or hold.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= WB_BUBBLE;
        end else if (bubble) begin
            q <= WB_BUBBLE;
        end else if (load_en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline MEM stage: drives a handshaked data-memory bus for loads and
// stores, stalls earlier stages while the access is outstanding, guards the
// bus with a watchdog, flags misaligned accesses, and resolves branch/jump
// targets.
// Optional feature: define OVERFLOW_TRAP_EN to turn MEM_Overflow into a
// trap (write-back suppressed, Exc_Ov pulsed); otherwise Exc_Ov stays 0.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [31:0] MEM_ALUout,
    input  logic [31:0] MEM_busB,
    input  logic [4:0]  MEM_Rw,
    input  logic        MEM_RegWr,
    input  logic        MEM_MemtoReg,
    input  logic        MEM_MemWr,
    input  logic        MEM_Branch,
    input  logic        MEM_Jump,
    input  logic        MEM_Zero,
    input  logic        MEM_Overflow,
    input  logic [31:0] MEM_Btarg,
    input  logic [31:0] MEM_Jtarg,
    output logic        DM_Req,
    output logic        DM_We,
    output logic [31:0] DM_Addr,
    output logic [31:0] DM_Wdata,
    input  logic        DM_Ack,
    input  logic [31:0] DM_Rdata,
    output logic        Stall,
    output logic        PCSrc,
    output logic [31:0] NextPC,
    output logic [31:0] WB_Dout,
    output logic [31:0] WB_ALUout,
    output logic [4:0]  WB_Rw,
    output logic        WB_RegWr,
    output logic        WB_MemtoReg,
    output logic        Exc_AdE,
    output logic        Bus_Err,
    output logic        Exc_Ov
);

    // Last counter value before the watchdog fires (TIMEOUT WAIT cycles).
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic        req_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] rdata_r;
    logic        berr_pend_r;

    logic        mem_op_s;
    logic        misaligned_s;
    logic        start_s;
    logic        stall_s;
    logic        adel_s;
    logic        berr_s;
    logic        ov_trap_s;
    wb_entry_t   wb_d_s;
    wb_entry_t   wb_q_s;

    assign mem_op_s     = MEM_MemtoReg | MEM_MemWr;
    assign misaligned_s = is_misaligned(MEM_ALUout);
    assign start_s      = (state_r == ST_IDLE) & mem_op_s & ~misaligned_s;

    // Stall covers the launch cycle and every WAIT cycle; reset overrides
    // it at once so the pipeline is released while Clr is high.
    assign stall_s = ~Clr & (start_s | (state_r == ST_WAIT));

    assign adel_s = (state_r == ST_IDLE) & mem_op_s & misaligned_s;
    assign berr_s = (state_r == ST_DONE) & berr_pend_r;

`ifdef OVERFLOW_TRAP_EN
    assign ov_trap_s = MEM_Overflow;
`else
    // Overflow is ignored in this build.
    assign ov_trap_s = MEM_Overflow & 1'b0;
`endif

    // Access sequencer with watchdog; bus outputs are registered and held
    // for the whole WAIT phase.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            rdata_r     <= 32'd0;
            berr_pend_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r     <= ST_WAIT;
                        cnt_r       <= 8'd0;
                        req_r       <= 1'b1;
                        we_r        <= MEM_MemWr;
                        addr_r      <= MEM_ALUout;
                        wdata_r     <= MEM_busB;
                        berr_pend_r <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        req_r   <= 1'b0;
                        we_r    <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (DM_Ack) begin
                        state_r     <= ST_DONE;
                        cnt_r       <= 8'd0;
                        req_r       <= 1'b0;
                        we_r        <= 1'b0;
                        rdata_r     <= DM_Rdata;
                        berr_pend_r <= 1'b0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r     <= ST_DONE;
                        cnt_r       <= 8'd0;
                        req_r       <= 1'b0;
                        we_r        <= 1'b0;
                        rdata_r     <= 32'd0;
                        berr_pend_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    berr_pend_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= 8'd0;
                    req_r       <= 1'b0;
                    we_r        <= 1'b0;
                    berr_pend_r <= 1'b0;
                end
            endcase
        end
    end

    // Build the write-back entry for the instruction leaving MEM; any
    // exception suppresses the register write.
    always_comb begin
        wb_d_s          = WB_BUBBLE;
        wb_d_s.alu      = MEM_ALUout;
        wb_d_s.rw       = MEM_Rw;
        wb_d_s.memtoreg = MEM_MemtoReg;
        wb_d_s.exc_ade  = adel_s;
        wb_d_s.bus_err  = berr_s;
        wb_d_s.exc_ov   = ov_trap_s;
        wb_d_s.regwr    = MEM_RegWr & ~adel_s & ~berr_s & ~ov_trap_s;
        if ((state_r == ST_DONE) && MEM_MemtoReg) begin
            wb_d_s.dout = rdata_r;
        end else begin
            wb_d_s.dout = 32'd0;
        end
    end

    reg_mem_wb u_reg_mem_wb (
        .clk     (Clk),
        .clr     (Clr),
        .load_en (~stall_s),
        .bubble  (stall_s),
        .d       (wb_d_s),
        .q       (wb_q_s)
    );

    assign DM_Req   = req_r;
    assign DM_We    = we_r;
    assign DM_Addr  = addr_r;
    assign DM_Wdata = wdata_r;
    assign Stall    = stall_s;

    assign PCSrc  = (MEM_Branch & MEM_Zero) | MEM_Jump;
    assign NextPC = MEM_Jump ? MEM_Jtarg : MEM_Btarg;

    assign WB_Dout     = wb_q_s.dout;
    assign WB_ALUout   = wb_q_s.alu;
    assign WB_Rw       = wb_q_s.rw;
    assign WB_RegWr    = wb_q_s.regwr;
    assign WB_MemtoReg = wb_q_s.memtoreg;
    assign Exc_AdE     = wb_q_s.exc_ade;
    assign Bus_Err     = wb_q_s.bus_err;
    assign Exc_Ov      = wb_q_s.exc_ov;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: Clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have ports: Clr  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: MEM_ALUout  in  32  memory address or ALU result; MEM_busB  in  32  store data; MEM_Rw  in  5  destination register.
REQ-004 SHALL have ports: MEM_RegWr, MEM_MemtoReg (load), MEM_MemWr (store), MEM_Branch, MEM_Jump, MEM_Zero, MEM_Overflow  in  1 each; MEM_Btarg, MEM_Jtarg  in  32.
REQ-005 SHALL have ports: DM_Req  out  1; DM_We  out  1; DM_Addr  out  32; DM_Wdata  out  32; DM_Ack  in  1; DM_Rdata  in  32.
REQ-006 SHALL have ports: Stall  out  1  hold EX/MEM and earlier stages; PCSrc  out  1; NextPC  out  32.
REQ-007 SHALL have ports: WB_Dout  out  32; WB_ALUout  out  32; WB_Rw  out  5; WB_RegWr  out  1; WB_MemtoReg  out  1; Exc_AdE  out  1; Bus_Err  out  1; Exc_Ov  out  1.
REQ-008 SHALL have parameter: TIMEOUT, default 255, maximum DM_Ack wait in cycles (8-bit counter).

Function
REQ-009 SHALL treat "mem_op" as MEM_MemtoReg | MEM_MemWr and "misaligned" as MEM_ALUout[1:0] != 0.
REQ-010 SHALL implement FSM IDLE -> WAIT -> DONE -> IDLE.
REQ-011 IDLE: mem_op & aligned -> WAIT next cycle, Stall=1; otherwise stay IDLE, Stall=0.
REQ-012 WAIT: DM_Req=1, DM_We=MEM_MemWr, DM_Addr=MEM_ALUout, DM_Wdata=MEM_busB, all held stable until DM_Ack; Stall=1.
REQ-013 WAIT with DM_Ack=1: capture DM_Rdata, go DONE; DM_Req drops the following cycle.
REQ-014 WAIT counter reaching TIMEOUT without DM_Ack: go DONE with Bus_Err pending; captured data = 0.
REQ-015 DONE: Stall=0, DM_Req=0; next edge loads WB registers; next state IDLE.
REQ-016 Minimum load/store latency SHALL be 3 cycles (IDLE, WAIT with same-cycle Ack, DONE); non-memory ops 1 cycle, no stall.
REQ-017 WB registers SHALL load every edge where Stall=0; WB_Dout = captured data for loads, else 0.
REQ-018 While Stall=1, WB registers SHALL load a bubble (WB_RegWr=0) so WB never repeats a write.
REQ-019 Misaligned mem_op: no DM_Req, no stall; WB_RegWr=0; Exc_AdE=1 for exactly one cycle.
REQ-020 Bus timeout: WB_RegWr=0 in loaded WB entry; Bus_Err=1 for exactly one cycle.
REQ-021 DM_Ack in IDLE or DONE SHALL be ignored.
REQ-022 PCSrc = (MEM_Branch & MEM_Zero) | MEM_Jump, combinational; NextPC = Jtarg if Jump, else Btarg; Jump wins if both.

Reset
REQ-023 Clr=1 SHALL immediately force IDLE, counter 0, DM_Req=0, Stall=0, all WB_* / Exc_* / Bus_Err = 0.
REQ-024 Clr asserted in WAIT SHALL abandon the access with no WB write and no error flag.

Configuration
REQ-025 With OVERFLOW_TRAP_EN defined: MEM_Overflow=1 forces WB_RegWr=0 and pulses Exc_Ov one cycle; without it, overflow is ignored and Exc_Ov is tied 0.

Structure
REQ-026 Package mem_access_pkg SHALL hold the FSM state encoding (IDLE=0, WAIT=1, DONE=2) and the default TIMEOUT constant.
REQ-027 The MEM/WB register SHALL be sub-module reg_mem_wb (load enable, bubble insert, async clear); FSM, watchdog and branch logic stay in the top.

Verification
REQ-028 Load at 0x00000010, DM_Ack after 2 WAIT cycles with Rdata=0xDEADBEEF -> Stall high 3 cycles, WB_Dout=0xDEADBEEF, WB_MemtoReg=1, one WB_RegWr pulse.
REQ-029 Store 0x12345678 to 0x00000020, Ack same cycle -> DM_We=1, DM_Wdata=0x12345678 for one Req cycle, WB_RegWr=0.
REQ-030 Load at 0x00000013 -> no DM_Req, Exc_AdE one cycle, Stall=0, WB_RegWr=0.
REQ-031 Load, DM_Ack never asserted, TIMEOUT=4 -> DONE after 4 WAIT cycles, Bus_Err one cycle, WB_RegWr=0.
REQ-032 Clr pulse during WAIT -> DM_Req and Stall low immediately, FSM IDLE, no WB write.
REQ-033 Branch=1, Zero=1, Jump=1, Btarg=0x100, Jtarg=0x200 -> PCSrc=1, NextPC=0x200; with OVERFLOW_TRAP_EN, Overflow=1 on ALU op -> Exc_Ov pulse, WB_RegWr=0.
